// File: rtl/risc_pkg.sv
// risc_pkg
// Shared definitions for the multi-cycle RISC core and its ALU:
//   - opcode_e : primary opcodes (instruction bits [15:12])
//   - funct_e  : ALU function codes (instruction bits [2:0])
//   - state_e  : sequencing states of the core FSM
//   - instruction field bit positions and INSTR_W
//   - is_legal : true for every defined opcode
package risc_pkg;

   localparam int INSTR_W   = 16;

   localparam int OP_MSB    = 15;
   localparam int OP_LSB    = 12;
   localparam int RS_MSB    = 11;
   localparam int RS_LSB    = 9;
   localparam int RT_MSB    = 8;
   localparam int RT_LSB    = 6;
   localparam int RD_MSB    = 5;
   localparam int RD_LSB    = 3;
   localparam int FUNCT_MSB = 2;
   localparam int FUNCT_LSB = 0;
   localparam int IMM_MSB   = 5;
   localparam int IMM_LSB   = 0;
   localparam int OFF_MSB   = 11;
   localparam int OFF_LSB   = 0;

   typedef enum logic [3:0] {
      OP_LD   = 4'b0000,
      OP_ST   = 4'b0001,
      OP_ALU  = 4'b0010,
      OP_ADDI = 4'b0011,
      OP_BEQ  = 4'b1011,
      OP_BNE  = 4'b1100,
      OP_JMP  = 4'b1101,
      OP_HALT = 4'b1111
   } opcode_e;

   typedef enum logic [2:0] {
      F_ADD = 3'b000,
      F_SUB = 3'b001,
      F_AND = 3'b010,
      F_OR  = 3'b011,
      F_XOR = 3'b100,
      F_SLL = 3'b101,
      F_SRL = 3'b110,
      F_SLT = 3'b111
   } funct_e;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_e;

   // Opcodes not listed here trap the core into HALT with illegal_op set.
   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         OP_LD, OP_ST, OP_ALU, OP_ADDI,
         OP_BEQ, OP_BNE, OP_JMP, OP_HALT: is_legal = 1'b1;
         default:                         is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/risc_alu.sv
// risc_alu
// Purely combinational ALU shared by register ops, ADDI and address generation.
// Ports:
//   a, b  : DATA_W operands
//   funct : operation select (funct_e)
//   y     : DATA_W result; arithmetic wraps modulo 2^DATA_W
module risc_alu
   import risc_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  funct_e            funct,
   output logic [DATA_W-1:0] y
);

   localparam int SH_W = $clog2(DATA_W);

   // Shifts only use the low log2(DATA_W) bits of b; SLT is a signed compare
   // producing exactly 0 or 1.
   always_comb begin
      y = '0;
      case (funct)
         F_ADD: y = a + b;
         F_SUB: y = a - b;
         F_AND: y = a & b;
         F_OR:  y = a | b;
         F_XOR: y = a ^ b;
         F_SLL: y = a << b[SH_W-1:0];
         F_SRL: y = a >> b[SH_W-1:0];
         F_SLT: y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/risc_multicycle_core.sv
// risc_multicycle_core
// FSM-sequenced multi-cycle core with one shared memory port (req/ready
// handshake, so memories may insert wait states).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   mem_req/mem_we      : registered request and direction, held until accepted
//   mem_addr/mem_wdata  : registered word address and store data
//   mem_ready/mem_rdata : transfer completes when mem_req && mem_ready
//   retire              : one-cycle pulse per completed instruction
//   halted, illegal_op  : stop status; illegal_op is sticky until reset
//   pc_dbg              : current PC
// Requires DATA_W >= 16, ADDR_W >= 12 and ADDR_W <= DATA_W.
module risc_multicycle_core
   import risc_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              retire,
   output logic              halted,
   output logic              illegal_op,
   output logic [ADDR_W-1:0] pc_dbg
);

   state_e              state;
   logic [INSTR_W-1:0]  ir;
   logic [ADDR_W-1:0]   pc;
   logic [DATA_W-1:0]   regs [0:7];
   logic [DATA_W-1:0]   a_reg;
   logic [DATA_W-1:0]   b_reg;
   logic [DATA_W-1:0]   wb_data;

   logic [3:0]          op;
   logic [2:0]          rs;
   logic [2:0]          rt;
   logic [2:0]          rd;
   logic [DATA_W-1:0]   imm_ext;
   logic [ADDR_W-1:0]   br_off;
   logic [ADDR_W-1:0]   jmp_off;
   logic [ADDR_W-1:0]   next_pc;
   logic [DATA_W-1:0]   alu_b;
   funct_e              alu_f;
   logic [DATA_W-1:0]   alu_y;

   assign op      = ir[OP_MSB:OP_LSB];
   assign rs      = ir[RS_MSB:RS_LSB];
   assign rt      = ir[RT_MSB:RT_LSB];
   assign rd      = ir[RD_MSB:RD_LSB];
   assign imm_ext = {{(DATA_W-6){ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};
   assign br_off  = {{(ADDR_W-6){ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};
   assign jmp_off = {{(ADDR_W-12){ir[OFF_MSB]}}, ir[OFF_MSB:OFF_LSB]};
   assign pc_dbg  = pc;

   // Register ops use rs funct rt; ADDI, LD and ST all reuse the adder with
   // the sign-extended immediate as second operand.
   always_comb begin
      alu_b = b_reg;
      alu_f = funct_e'(ir[FUNCT_MSB:FUNCT_LSB]);
      if (op != OP_ALU) begin
         alu_b = imm_ext;
         alu_f = F_ADD;
      end
   end

   risc_alu #(.DATA_W(DATA_W)) u_alu (
      .a     (a_reg),
      .b     (alu_b),
      .funct (alu_f),
      .y     (alu_y)
   );

   // pc already points past the branch (incremented in FETCH), so the target
   // is simply pc + offset; untaken branches fall through to pc.
   always_comb begin
      next_pc = pc;
      case (op)
         OP_BEQ:  if (a_reg == b_reg) next_pc = pc + br_off;
         OP_BNE:  if (a_reg != b_reg) next_pc = pc + br_off;
         OP_JMP:  next_pc = pc + jmp_off;
         default: next_pc = pc;
      endcase
   end

   // Main sequencer. Every path back into FETCH raises mem_req with the new
   // PC in the same edge, so a fetch request is visible in the first FETCH
   // cycle; only the very first fetch after reset spends one extra cycle
   // raising the request because reset forces mem_req low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_FETCH;
         pc         <= RESET_PC;
         ir         <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         wb_data    <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         retire     <= 1'b0;
         halted     <= 1'b0;
         illegal_op <= 1'b0;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         retire <= 1'b0;
         case (state)
            S_FETCH: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
               end else if (mem_ready) begin
                  ir      <= mem_rdata[INSTR_W-1:0];
                  pc      <= pc + ADDR_W'(1);
                  mem_req <= 1'b0;
                  state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               a_reg <= (rs == 3'd0) ? '0 : regs[rs];
               b_reg <= (rt == 3'd0) ? '0 : regs[rt];
               if (!is_legal(op)) begin
                  illegal_op <= 1'b1;
                  halted     <= 1'b1;
                  state      <= S_HALT;
               end else if (op == OP_HALT) begin
                  halted <= 1'b1;
                  retire <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (op)
                  OP_ALU, OP_ADDI: begin
                     wb_data <= alu_y;
                     state   <= S_WB;
                  end
                  OP_LD, OP_ST: begin
                     mem_req   <= 1'b1;
                     mem_we    <= (op == OP_ST);
                     mem_addr  <= alu_y[ADDR_W-1:0];
                     mem_wdata <= b_reg;
                     state     <= S_MEM;
                  end
                  OP_BEQ, OP_BNE, OP_JMP: begin
                     pc       <= next_pc;
                     retire   <= 1'b1;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= next_pc;
                     state    <= S_FETCH;
                  end
                  default: state <= S_HALT;
               endcase
            end
            S_MEM: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (op == OP_ST) begin
                     retire   <= 1'b1;
                     mem_req  <= 1'b1;
                     mem_addr <= pc;
                     state    <= S_FETCH;
                  end else begin
                     wb_data <= mem_rdata;
                     state   <= S_WB;
                  end
               end
            end
            S_WB: begin
               if (op == OP_ALU) begin
                  if (rd != 3'd0) regs[rd] <= wb_data;
               end else begin
                  if (rt != 3'd0) regs[rt] <= wb_data;
               end
               retire   <= 1'b1;
               mem_req  <= 1'b1;
               mem_we   <= 1'b0;
               mem_addr <= pc;
               state    <= S_FETCH;
            end
            S_HALT: begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               halted  <= 1'b1;
            end
            default: state <= S_HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_risc_multicycle_core.sv
// tb_risc_multicycle_core
// Directed programs run against a behavioural memory with programmable wait
// states. Every expected bus transfer (fetch address, load address, store
// address and data) is queued up front; the memory model pops and compares
// each completed transfer and checks request stability during wait cycles.
module tb_risc_multicycle_core;

   localparam int          DATA_W   = 16;
   localparam int          ADDR_W   = 16;
   localparam logic [15:0] RESET_PC = 16'h0000;

   localparam logic [3:0] T_LD   = 4'b0000;
   localparam logic [3:0] T_ST   = 4'b0001;
   localparam logic [3:0] T_ADDI = 4'b0011;
   localparam logic [3:0] T_BEQ  = 4'b1011;
   localparam logic [3:0] T_BNE  = 4'b1100;
   localparam logic [15:0] T_HALT = 16'hF000;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
   } xfer_t;

   logic              clk;
   logic              rst;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic              retire;
   logic              halted;
   logic              illegal_op;
   logic [ADDR_W-1:0] pc_dbg;

   logic [15:0] mem [0:255];
   xfer_t       exp_q [$];
   int          stamps [$];
   int          wait_n;
   int          wcnt;
   int          cyc;
   int          tests_run;
   int          tests_failed;

   risc_multicycle_core #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .retire     (retire),
      .halted     (halted),
      .illegal_op (illegal_op),
      .pc_dbg     (pc_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rs,
                                         input logic [2:0] rt, input logic [5:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [15:0] enc_r(input logic [2:0] rs, input logic [2:0] rt,
                                         input logic [2:0] rd, input logic [2:0] f);
      return {4'b0010, rs, rt, rd, f};
   endfunction

   task automatic pushF(input logic [15:0] a);
      exp_q.push_back('{we: 1'b0, addr: a, data: 16'h0});
   endtask

   task automatic pushW(input logic [15:0] a, input logic [15:0] d);
      exp_q.push_back('{we: 1'b1, addr: a, data: d});
   endtask

   task automatic clearMem();
      for (int i = 0; i < 256; i++) mem[i] = T_HALT;
   endtask

   // Memory model and scoreboard monitor: sampled on the falling edge, the
   // ready decision for the following rising edge is made here, so a
   // transfer is known to complete when ready is raised.
   always @(negedge clk) begin
      xfer_t e;
      if (retire) stamps.push_back(cyc);
      if (rst || !mem_req) begin
         mem_ready = 1'b0;
         wcnt      = 0;
      end else if (wcnt >= wait_n) begin
         mem_ready = 1'b1;
         mem_rdata = mem[mem_addr[7:0]];
         if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected transfer: got we=%0b addr=0x%0h, expected none", mem_we, mem_addr);
         end else begin
            e = exp_q.pop_front();
            checkOutput("xfer we", {31'b0, mem_we}, {31'b0, e.we});
            checkOutput("xfer addr", {16'b0, mem_addr}, {16'b0, e.addr});
            if (e.we) checkOutput("store data", {16'b0, mem_wdata}, {16'b0, e.data});
         end
         wcnt = 0;
      end else begin
         mem_ready = 1'b0;
         wcnt++;
         if (exp_q.size() != 0) begin
            checkOutput("wait addr stable", {16'b0, mem_addr}, {16'b0, exp_q[0].addr});
            checkOutput("wait we stable", {31'b0, mem_we}, {31'b0, exp_q[0].we});
         end
      end
   end

   task automatic doReset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset mem_req", {31'b0, mem_req}, 0);
      checkOutput("reset mem_we", {31'b0, mem_we}, 0);
      checkOutput("reset mem_addr", {16'b0, mem_addr}, 0);
      checkOutput("reset mem_wdata", {16'b0, mem_wdata}, 0);
      checkOutput("reset retire", {31'b0, retire}, 0);
      checkOutput("reset halted", {31'b0, halted}, 0);
      checkOutput("reset illegal_op", {31'b0, illegal_op}, 0);
      checkOutput("reset pc", {16'b0, pc_dbg}, {16'b0, RESET_PC});
      stamps.delete();
      rst = 1'b0;
   endtask

   task automatic applyStimulus(input int wait_cycles, input int budget);
      wait_n = wait_cycles;
      doReset();
      for (int i = 0; i < budget && !halted; i++) @(negedge clk);
      checkOutput("halt reached", {31'b0, halted}, 1);
      repeat (3) @(negedge clk);
      checkOutput("scoreboard drained", exp_q.size(), 0);
   endtask

   function automatic int gap(input int idx);
      return (stamps.size() > idx) ? stamps[idx] - stamps[idx-1] : -1;
   endfunction

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Directed programs: arithmetic with zero-wait memory, load/store with
   // two wait states, branches and r0, jump self-loop with reset during a
   // stalled fetch, and the illegal-opcode trap.
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      mem_ready    = 1'b0;
      mem_rdata    = '0;
      wait_n       = 0;
      wcnt         = 0;
      cyc          = 0;

      clearMem();
      mem[0]  = enc_i(T_ADDI, 3'd0, 3'd1, 6'd5);
      mem[1]  = enc_i(T_ADDI, 3'd0, 3'd2, 6'h3D);
      mem[2]  = enc_r(3'd1, 3'd2, 3'd3, 3'd0);
      mem[3]  = enc_i(T_ST,   3'd0, 3'd3, 6'd20);
      mem[4]  = enc_i(T_ADDI, 3'd0, 3'd6, 6'd1);
      mem[5]  = enc_r(3'd0, 3'd6, 3'd5, 3'd1);
      mem[6]  = enc_i(T_ST,   3'd0, 3'd5, 6'd21);
      mem[7]  = enc_r(3'd5, 3'd6, 3'd7, 3'd7);
      mem[8]  = enc_i(T_ST,   3'd0, 3'd7, 6'd22);
      mem[9]  = enc_r(3'd1, 3'd2, 3'd4, 3'd4);
      mem[10] = enc_i(T_ST,   3'd0, 3'd4, 6'd23);
      mem[11] = enc_r(3'd2, 3'd6, 3'd4, 3'd6);
      mem[12] = enc_i(T_ST,   3'd0, 3'd4, 6'd24);
      mem[13] = enc_r(3'd1, 3'd6, 3'd4, 3'd5);
      mem[14] = enc_i(T_ST,   3'd0, 3'd4, 6'd25);
      mem[15] = enc_r(3'd1, 3'd2, 3'd4, 3'd2);
      mem[16] = enc_i(T_ST,   3'd0, 3'd4, 6'd26);
      mem[17] = enc_r(3'd2, 3'd6, 3'd4, 3'd3);
      mem[18] = enc_i(T_ST,   3'd0, 3'd4, 6'd27);
      mem[19] = T_HALT;
      pushF(0); pushF(1); pushF(2); pushF(3); pushW(20, 16'h0002);
      pushF(4); pushF(5); pushF(6); pushW(21, 16'hFFFF);
      pushF(7); pushF(8); pushW(22, 16'h0001);
      pushF(9); pushF(10); pushW(23, 16'hFFF8);
      pushF(11); pushF(12); pushW(24, 16'h7FFE);
      pushF(13); pushF(14); pushW(25, 16'h000A);
      pushF(15); pushF(16); pushW(26, 16'h0005);
      pushF(17); pushF(18); pushW(27, 16'hFFFD);
      pushF(19);
      applyStimulus(0, 400);
      checkOutput("alu prog retires", stamps.size(), 20);
      checkOutput("addi latency", gap(1), 4);
      checkOutput("add latency", gap(2), 4);
      checkOutput("st latency", gap(3), 4);

      clearMem();
      mem[0] = enc_i(T_ADDI, 3'd0, 3'd1, 6'd5);
      mem[1] = enc_i(T_ST,   3'd0, 3'd1, 6'd10);
      mem[2] = enc_i(T_LD,   3'd0, 3'd4, 6'd10);
      mem[3] = enc_i(T_ST,   3'd0, 3'd4, 6'd11);
      mem[4] = enc_i(T_ADDI, 3'd0, 3'd2, 6'd12);
      mem[5] = enc_i(T_LD,   3'd2, 3'd3, 6'h3E);
      mem[6] = enc_i(T_ST,   3'd2, 3'd3, 6'd1);
      mem[7] = T_HALT;
      pushF(0); pushF(1); pushW(10, 16'h0005); pushF(2); pushF(10);
      pushF(3); pushW(11, 16'h0005); pushF(4); pushF(5); pushF(10);
      pushF(6); pushW(13, 16'h0005); pushF(7);
      applyStimulus(2, 600);
      checkOutput("ldst prog retires", stamps.size(), 8);
      checkOutput("st latency wait2", gap(1), 8);
      checkOutput("ld latency wait2", gap(2), 9);
      checkOutput("M[10]", {16'b0, mem[10]}, 32'h0005);

      clearMem();
      mem[0]  = enc_i(T_ADDI, 3'd0, 3'd1, 6'd7);
      mem[1]  = enc_i(T_ADDI, 3'd0, 3'd2, 6'd7);
      mem[2]  = enc_i(T_ADDI, 3'd0, 3'd0, 6'd5);
      mem[3]  = enc_i(T_ST,   3'd0, 3'd0, 6'd31);
      mem[4]  = enc_i(T_BEQ,  3'd1, 3'd2, 6'd2);
      mem[7]  = enc_i(T_BNE,  3'd1, 3'd2, 6'd2);
      mem[8]  = enc_i(T_ST,   3'd0, 3'd1, 6'd30);
      mem[9]  = enc_i(T_BNE,  3'd1, 3'd0, 6'd1);
      pushF(0); pushF(1); pushF(2); pushF(3); pushW(31, 16'h0000);
      pushF(4); pushF(7); pushF(8); pushW(30, 16'h0007); pushF(9); pushF(11);
      applyStimulus(0, 400);
      checkOutput("branch prog retires", stamps.size(), 9);
      checkOutput("beq latency", gap(4), 3);

      clearMem();
      mem[0] = 16'hDFFF;
      pushF(0); pushF(0); pushF(0);
      wait_n = 0;
      doReset();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      wait_n = 100;
      checkOutput("jmp loop fetches", exp_q.size(), 0);
      repeat (6) @(negedge clk);
      checkOutput("jmp retires", stamps.size(), 3);
      checkOutput("jmp latency", gap(1), 3);
      checkOutput("stalled fetch req", {31'b0, mem_req}, 1);
      checkOutput("stalled fetch addr", {16'b0, mem_addr}, 0);
      checkOutput("jmp wrap pc", {16'b0, pc_dbg}, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst aborts fetch", {31'b0, mem_req}, 0);
      checkOutput("rst pc", {16'b0, pc_dbg}, {16'b0, RESET_PC});

      clearMem();
      mem[0] = 16'h5000;
      pushF(0);
      applyStimulus(0, 100);
      checkOutput("illegal_op set", {31'b0, illegal_op}, 1);
      checkOutput("illegal halted", {31'b0, halted}, 1);
      checkOutput("illegal no retire", stamps.size(), 0);
      checkOutput("illegal pc", {16'b0, pc_dbg}, 1);
      repeat (5) @(negedge clk);
      checkOutput("halt no request", {31'b0, mem_req}, 0);

      mem[0] = T_HALT;
      pushF(0);
      applyStimulus(0, 100);
      checkOutput("halt retire", stamps.size(), 1);
      checkOutput("illegal_op cleared", {31'b0, illegal_op}, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
